// File: rtl/ntt_out_serializer.sv
// Captures one polynomial from a wide NTT result burst and re-emits it one coefficient per cycle.
// Define SER_BITREV_EN to emit entries in bit-reversed order (natural order for NTT outputs).
module ntt_out_serializer #(
  parameter int DW         = 64,
  parameter int PE_NUMBER  = 4,
  parameter int RING_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done_in,
  input  logic [2*PE_NUMBER*DW-1:0] bram_in,
  output logic [DW-1:0]             dout,
  output logic [RING_DEPTH-1:0]     dout_idx,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      overflow,
  output logic [1:0]                state_dbg
);

  localparam int LANES     = 2 * PE_NUMBER;
  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam int W         = RING_SIZE / LANES;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int WC_W      = RING_DEPTH - LANE_BITS;

  // Handshake: a coefficient transfers on every rising edge where dout_valid
  // and dout_ready are both high; dout_valid never waits on dout_ready and the
  // presented coefficient is held until it transfers.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WC_W-1:0]       wc;
  logic [RING_DEPTH-1:0] rc;
  logic [DW-1:0]         mem [RING_SIZE];
  logic                  hs, rc_last, cap_end, frame_end, drop;
  logic [RING_DEPTH-1:0] rd_ord, rd_addr;

`ifdef SER_BITREV_EN
  function automatic logic [RING_DEPTH-1:0] bitrev(input logic [RING_DEPTH-1:0] k);
    logic [RING_DEPTH-1:0] r;
    for (int i = 0; i < RING_DEPTH; i++) r[i] = k[RING_DEPTH-1-i];
    return r;
  endfunction
`endif

  always_comb begin
    hs        = dout_valid & dout_ready;
    rc_last   = (rc == RING_DEPTH'(RING_SIZE - 1));
    cap_end   = (state_q == CAPTURE) && (wc == WC_W'(W - 1));
    frame_end = hs && rc_last;
    drop      = done_in && (state_q != IDLE) && !frame_end;
    rd_ord    = cap_end ? '0 : rc + 1'b1;
`ifdef SER_BITREV_EN
    rd_addr   = bitrev(rd_ord);
    dout_idx  = bitrev(rc);
`else
    rd_addr   = rd_ord;
    dout_idx  = rc;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (done_in) state_d = CAPTURE;
      CAPTURE: if (cap_end) state_d = DRAIN;
      DRAIN:   if (frame_end) state_d = done_in ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    dout_valid = (state_q == DRAIN);
    dout_last  = dout_valid && rc_last;
    state_dbg  = state_q;
  end

  // The buffer carries no reset: its contents are only read after a full capture.
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) begin
      for (int n = 0; n < LANES; n++)
        mem[{wc, LANE_BITS'(n)}] <= bram_in[DW*n +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wc         <= '0;
      rc         <= '0;
      dout       <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (drop) overflow <= 1'b1;
      if (state_q == CAPTURE) wc <= wc + 1'b1;
      else                    wc <= '0;
      // Prefetch the next coefficient so dout is a plain register with no path from dout_ready.
      if (cap_end || (hs && !rc_last)) dout <= mem[rd_addr];
      if (cap_end || frame_end)        rc <= '0;
      else if (hs)                     rc <= rc + 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_out_serializer.sv
// Self-checking bench for ntt_out_serializer: timing vector table plus scoreboarded streaming scenarios.
module tb_ntt_out_serializer;
  localparam int DW         = 64;
  localparam int PE_NUMBER  = 4;
  localparam int RING_DEPTH = 8;
  localparam int LANES      = 2 * PE_NUMBER;
  localparam int RING_SIZE  = 1 << RING_DEPTH;
  localparam int W          = RING_SIZE / LANES;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  done_in = 1'b0;
  logic [LANES*DW-1:0]   bram_in = '0;
  logic                  dout_ready = 1'b1;
  logic [DW-1:0]         dout;
  logic [RING_DEPTH-1:0] dout_idx;
  logic                  dout_valid, dout_last, frame_done, busy, overflow;
  logic [1:0]            state_dbg;

  ntt_out_serializer #(.DW(DW), .PE_NUMBER(PE_NUMBER), .RING_DEPTH(RING_DEPTH)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .bram_in(bram_in),
    .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .frame_done(frame_done), .busy(busy), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int fd_count = 0;
  logic [DW-1:0] exp_q[$];
  int ord_q[$];

  typedef struct {
    int   off;
    logic valid;
    logic last;
    logic fdone;
    logic bsy;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [7:0] bitrev8(input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = k[7-i];
    return r;
  endfunction

  function automatic int exp_entry(input int k);
`ifdef SER_BITREV_EN
    return int'(bitrev8(8'(k)));
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_frame(input int base, input int extra_off);
    done_in = 1'b1;
    for (int k = 0; k < RING_SIZE; k++) begin
      exp_q.push_back(DW'(base + exp_entry(k)));
      ord_q.push_back(k);
    end
    for (int m = 0; m < W; m++) begin
      @(posedge clk);
      #1;
      done_in = (extra_off == m + 1);
      for (int n = 0; n < LANES; n++) bram_in[DW*n +: DW] = DW'(base + LANES * m + n);
    end
    @(posedge clk);
    #1;
    done_in = 1'b0;
    bram_in = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    ord_q.delete();
  endtask

  // ready pattern: constant 1, or 1,0,0 repeating
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) dout_ready = 1'b1;
      else begin
        dout_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // scoreboard: pop on every handshake, check held data while stalled
  always @(negedge clk) begin
    logic [DW-1:0] v;
    int k;
    if (frame_done) fd_count++;
    if (reset && dout_valid) begin
      if (dout_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          v = exp_q.pop_front();
          k = ord_q.pop_front();
          check("dout", dout, v);
          check("dout_idx", 64'(dout_idx), 64'(exp_entry(k)));
          check("dout_last", 64'(dout_last), 64'(k == RING_SIZE - 1));
        end
      end else if (exp_q.size() != 0) begin
        check("hold_dout", dout, exp_q[0]);
        check("hold_idx", 64'(dout_idx), 64'(exp_entry(ord_q[0])));
      end
    end
  end

  initial begin
    int t, fd0;
    vecs[0] = '{0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1,   1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{33,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{34,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{287, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{288, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{289, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{290, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset then idle
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 64'd0);
    check("rst_idx", 64'(dout_idx), 64'd0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_last", 64'(dout_last), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // basic stream with timing table
    fd0 = fd_count;
    t = cyc;
    fork
      send_frame(0, 0);
      for (int i = 0; i < 9; i++) begin
        sample(t + vecs[i].off);
        check($sformatf("vec%0d_valid", i), 64'(dout_valid), 64'(vecs[i].valid));
        check($sformatf("vec%0d_last", i), 64'(dout_last), 64'(vecs[i].last));
        check($sformatf("vec%0d_frame_done", i), 64'(frame_done), 64'(vecs[i].fdone));
        check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
        if (vecs[i].off == 33) check("first_value", dout, 64'(exp_entry(0)));
        if (vecs[i].off == 288) check("last_value", dout, 64'(exp_entry(255)));
      end
    join
    wait_drain();
    check("basic_frame_done_count", 64'(fd_count - fd0), 64'd1);

    // backpressure
    fd0 = fd_count;
    ready_mode = 1;
    send_frame(0, 0);
    wait_drain();
    ready_mode = 0;
    check("bp_frame_done_count", 64'(fd_count - fd0), 64'd1);
    check("bp_overflow", 64'(overflow), 64'd0);

    // overflow: extra done_in during CAPTURE and DRAIN
    fd0 = fd_count;
    t = cyc;
    fork
      send_frame(0, 10);
      begin
        sample(t + 10);
        check("ovf_before", 64'(overflow), 64'd0);
        sample(t + 11);
        check("ovf_after_capture_drop", 64'(overflow), 64'd1);
      end
    join
    goto(t + 100);
    done_in = 1'b1;
    @(posedge clk);
    #1;
    done_in = 1'b0;
    wait_drain();
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_frame_done_count", 64'(fd_count - fd0), 64'd1);
    check("ovf_idle", 64'(busy), 64'd0);
    pulse_reset();
    check("ovf_cleared_by_reset", 64'(overflow), 64'd0);

    // back-to-back frames: second done_in on the final handshake
    fd0 = fd_count;
    t = cyc;
    send_frame(0, 0);
    goto(t + 288);
    fork
      send_frame(1000, 0);
      begin
        sample(t + 289);
        check("b2b_frame_done", 64'(frame_done), 64'd1);
        check("b2b_busy", 64'(busy), 64'd1);
        sample(t + 288 + 33);
        check("b2b_second_valid", 64'(dout_valid), 64'd1);
      end
    join
    wait_drain();
    check("b2b_overflow", 64'(overflow), 64'd0);
    check("b2b_frame_done_count", 64'(fd_count - fd0), 64'd2);

    // reset mid-frame, then a fresh frame under backpressure
    t = cyc;
    send_frame(0, 0);
    goto(t + 150);
    pulse_reset();
    sample(t + 151);
    check("mid_rst_valid", 64'(dout_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_dout", dout, 64'd0);
    check("mid_rst_idx", 64'(dout_idx), 64'd0);
    check("mid_rst_last", 64'(dout_last), 64'd0);
    @(posedge clk);
    #1;
    fd0 = fd_count;
    ready_mode = 1;
    send_frame(0, 0);
    wait_drain();
    ready_mode = 0;
    check("fresh_frame_done_count", 64'(fd_count - fd0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_out_serializer.md
# ntt_out_serializer

Downstream stage of the NTT/INTT cores. It captures the wide result burst (2·PE_NUMBER coefficients per cycle) that a core streams on its `bramOut` bus after pulsing `done`, buffers one full polynomial, and re-emits it one coefficient per cycle over a valid/ready handshake. This lets narrow consumers such as DMA, host readback or the accumulator path take results at their own pace.

## Interface
- `DW`, default 64: coefficient width (`DATA_SIZE_ARB`).
- `PE_NUMBER`, default 4: butterfly units upstream; the input word holds 2·PE_NUMBER coefficients.
- `RING_DEPTH`, default 8: log2 of the ring size. RING_SIZE = 2^RING_DEPTH; W = RING_SIZE/(2·PE_NUMBER) words per frame.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low. `reset==0` at a rising edge clears all state.
- `done_in`, in, 1: one-cycle frame-start pulse from the core's `done`.
- `bram_in`, in, 2·PE_NUMBER·DW: result word. Coefficient n of word m sits at bits [DW·n +: DW] and has polynomial index (2·PE_NUMBER)·m+n.
- `dout`, out, DW: coefficient. Reset value 0.
- `dout_idx`, out, RING_DEPTH: polynomial index of `dout`. Reset value 0.
- `dout_valid`, out, 1: reset value 0.
- `dout_ready`, in, 1: consumer accept.
- `dout_last`, out, 1: high with the final coefficient of a frame. Reset value 0.
- `frame_done`, out, 1: one-cycle pulse after the last handshake. Reset value 0.
- `busy`, out, 1: state ≠ IDLE. Reset value 0.
- `overflow`, out, 1: sticky; set when a `done_in` is dropped, cleared only by reset. Reset value 0.

## Operation
- Buffer: RING_SIZE×DW memory, written 2·PE_NUMBER entries per cycle, read one entry per cycle.
- States:
  - IDLE: `done_in`=1 → CAPTURE; word counter wc=0.
  - CAPTURE: every cycle, store `bram_in` as word wc, then wc++. After word W-1 → DRAIN with read counter rc=0. There is no stall: the upstream burst is unconditional.
  - DRAIN: present coefficient rc.
    - Handshake = `dout_valid & dout_ready`.
    - On handshake, rc++ and the next coefficient appears on the following cycle.
    - On the handshake with rc=RING_SIZE-1: `dout_last` is high during it, then `frame_done` pulses on the next cycle and the state goes to IDLE.
- Output hold: `dout`, `dout_idx` and `dout_last` stay stable while `dout_valid & !dout_ready`.
- `dout_idx` equals the emitted order index rc, or its bit-reverse (see Configuration).
- Simultaneous events:
  - `done_in` in the same cycle as the final DRAIN handshake is accepted: the next state is CAPTURE and `frame_done` still pulses.
  - Any other `done_in` outside IDLE is ignored and sets `overflow`. The in-progress frame is unaffected.
- Reset mid-frame discards the partial frame and returns to IDLE with all outputs at reset values. The buffer contents are don't-care.

## Timing
- `done_in` high at cycle t means word 0 is on `bram_in` at t+1 and word W-1 at t+W. This matches the core's readout.
- First `dout_valid` at t+W+1. Registered outputs: no combinational path from `dout_ready` to any output.
- With `dout_ready` held high: one coefficient per cycle, last at t+W+RING_SIZE, `frame_done` at t+W+RING_SIZE+1.
- Minimum frame-to-frame spacing: W+RING_SIZE cycles from `done_in` to the next accepted `done_in`.

## Configuration
- `SER_BITREV_EN` defined: the k-th emitted coefficient is buffer entry bitrev(k, RING_DEPTH), and `dout_idx`=bitrev(k). This converts the core's bit-reversed NTT output to natural order.
- `SER_BITREV_EN` undefined: entries are emitted in buffer order and `dout_idx`=k. No reversal logic is instantiated.

## Test plan
Defaults throughout: DW=64, PE_NUMBER=4, RING_DEPTH=8, so W=32.
- Reset then idle, with `reset`=0 for 3 cycles → all outputs 0, `busy`=0.
- Basic stream: `done_in` at t, words m=0..31 with coefficient value 8m+n, `dout_ready`=1 → `dout_valid` first at t+33. Coefficient k has value k and `dout_idx`=k. `dout_last` at t+288, `frame_done` at t+289. With `SER_BITREV_EN` defined, emitted value = `dout_idx` = bitrev8(k); e.g. k=1 emits 128.
- Backpressure: same frame, `dout_ready` toggling 1,0,0,1… → every value 0..255 appears exactly once, in order. `dout`/`dout_idx` are held during ready=0 cycles.
- Overflow: extra `done_in` at t+10 (CAPTURE) and at t+100 (DRAIN) → `overflow`=1 from t+11 onward. The output frame is still exactly 0..255.
- Back-to-back frames: second `done_in` coincident with the final handshake, second frame holding values 1000+k → the second frame streams correctly, `overflow` stays 0, and two `frame_done` pulses are seen.
- Reset mid-frame: `reset`=0 for 1 cycle at t+150 → `dout_valid`=0 and `busy`=0 next cycle. A fresh frame after that streams correctly.
